kogge_pipe: RTL

//  Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready flow control.

---
 rtl/kogge_pkg.sv | 28 ++
 rtl/kogge_pipe_stg.sv | 58 +++++
 rtl/kogge_pipe.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/kogge_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder.
package kogge_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Number of prefix register stages; the last group takes the remainder.
  function automatic int nstg(input int width, input int lps);
    return (clog2(width) + lps - 1) / lps;
  endfunction

  function automatic gp_t black(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/kogge_pipe_stg.sv
// One pipeline stage: applies prefix levels LVL_LO..LVL_LO+LVL_CNT-1, then registers them.
module kogge_pipe_stg
  import kogge_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int LVL_LO  = 0,
  parameter int LVL_CNT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_i,
  input  logic                  ld_i,
  input  gp_t  [WIDTH-1:0]      gp_i,
  input  logic [WIDTH-1:0]      praw_i,
  input  logic                  cin_i,
  output logic                  vld_o,
  output gp_t  [WIDTH-1:0]      gp_o,
  output logic [WIDTH-1:0]      praw_o,
  output logic                  cin_o
);

  gp_t  [WIDTH-1:0] gp_d, lvl_prev;
  gp_t  [WIDTH-1:0] gp_q;
  logic [WIDTH-1:0] praw_q;
  logic             cin_q, vld_q;

  // Each level reads the previous level's snapshot, so bits never see same-level updates.
  always_comb begin
    gp_d     = gp_i;
    lvl_prev = gp_i;
    for (int k = 0; k < LVL_CNT; k++) begin
      lvl_prev = gp_d;
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << (LVL_LO + k)))
          gp_d[i] = black(lvl_prev[i], lvl_prev[i - (1 << (LVL_LO + k))]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    vld_q <= 1'b0;
    else if (ld_i) vld_q <= vld_i;
  end

  always_ff @(posedge clk) begin
    if (ld_i && vld_i) begin
      gp_q   <= gp_d;
      praw_q <= praw_i;
      cin_q  <= cin_i;
    end
  end

  assign vld_o  = vld_q;
  assign gp_o   = gp_q;
  assign praw_o = praw_q;
  assign cin_o  = cin_q;

endmodule

// File: rtl/kogge_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Define KOGGE_FLAGS_EN to add registered overflow (V) and zero (Z) outputs.
module kogge_pipe
  import kogge_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int LVLS_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef KOGGE_FLAGS_EN
  ,
  output logic             V,
  output logic             Z
`endif
);

  localparam int LOG2W = clog2(WIDTH);
  localparam int NSTG  = nstg(WIDTH, LVLS_PER_STG);

  // Index 0 is the P/G stage, 1..NSTG the prefix stages, NSTG+1 the output register.
  logic [NSTG+1:0]              vld_pipe, ld;
  gp_t  [NSTG:0][WIDTH-1:0]     gp_s;
  logic [NSTG:0][WIDTH-1:0]     praw_s;
  logic [NSTG:0]                cin_s;

  logic                         v0_q, vout_q;
  gp_t  [WIDTH-1:0]             gp0_d, gp0_q;
  logic [WIDTH-1:0]             praw0_q;
  logic                         cin0_q;
  logic [WIDTH-1:0]             bx, p0, g0;

  logic [WIDTH-1:0]             gf, pf, s_d, s_q;
  logic                         cout_d, cout_q;
  logic                         unused_pf;

  // Load chain: a register takes new data when empty or when its successor loads.
  always_comb begin
    ld           = '0;
    ld[NSTG+1]   = ~vout_q | out_ready;
    for (int j = NSTG; j >= 0; j--) ld[j] = ~vld_pipe[j] | ld[j+1];
  end

  assign in_ready = rst_n & ld[0];

  always_comb begin
    bx = Sub ? ~B : B;
    p0 = A ^ bx;
    g0 = A & bx;
    for (int i = 0; i < WIDTH; i++) gp0_d[i] = '{g: g0[i], p: p0[i]};
    gp0_d[0].g = g0[0] | (p0[0] & Cin);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     v0_q <= 1'b0;
    else if (ld[0]) v0_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      gp0_q   <= gp0_d;
      praw0_q <= p0;
      cin0_q  <= Cin;
    end
  end

  assign vld_pipe[0]      = v0_q;
  assign gp_s[0]          = gp0_q;
  assign praw_s[0]        = praw0_q;
  assign cin_s[0]         = cin0_q;
  assign vld_pipe[NSTG+1] = vout_q;

  for (genvar s = 1; s <= NSTG; s++) begin : g_stg
    localparam int LO  = (s - 1) * LVLS_PER_STG;
    localparam int CNT = (LOG2W - LO < LVLS_PER_STG) ? (LOG2W - LO) : LVLS_PER_STG;
    kogge_pipe_stg #(.WIDTH(WIDTH), .LVL_LO(LO), .LVL_CNT(CNT)) u_stg (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (vld_pipe[s-1]),
      .ld_i   (ld[s]),
      .gp_i   (gp_s[s-1]),
      .praw_i (praw_s[s-1]),
      .cin_i  (cin_s[s-1]),
      .vld_o  (vld_pipe[s]),
      .gp_o   (gp_s[s]),
      .praw_o (praw_s[s]),
      .cin_o  (cin_s[s])
    );
  end

  // Final prefix generate of bit i is the carry out of bit i.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      gf[i] = gp_s[NSTG][i].g;
      pf[i] = gp_s[NSTG][i].p;
    end
    s_d    = praw_s[NSTG] ^ {gf[WIDTH-2:0], cin_s[NSTG]};
    cout_d = gf[WIDTH-1];
  end

  assign unused_pf = ^pf;

`ifdef KOGGE_FLAGS_EN
  logic v_q, z_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      z_q <= 1'b0;
    end else if (ld[NSTG+1] && vld_pipe[NSTG]) begin
      v_q <= gf[WIDTH-1] ^ gf[WIDTH-2];
      z_q <= (s_d == '0);
    end
  end

  assign V = v_q;
  assign Z = z_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vout_q <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
    end else if (ld[NSTG+1]) begin
      vout_q <= vld_pipe[NSTG];
      if (vld_pipe[NSTG]) begin
        s_q    <= s_d;
        cout_q <= cout_d;
      end
    end
  end

  assign out_valid = vout_q;
  assign S         = s_q;
  assign Cout      = cout_q;

endmodule
